// File: rtl/rca_config_ctrl.sv
// RCA reconfiguration sequencer: per-RCA shadow register banks written one port at a time,
// copied atomically to the active bank once the target RCA has drained its in-flight uses.
module rca_config_ctrl #(
    parameter int NUM_RCAS        = 3,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int ID_W            = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [$clog2(NUM_RCAS)-1:0]       req_rca_sel,
    input  logic [$clog2(NUM_READ_PORTS)-1:0] req_port_sel,
    input  logic                              req_src_dest,
    input  logic [4:0]                        req_reg_addr,
    input  logic                              req_commit,
    input  logic [ID_W-1:0]                   req_id,
    input  logic [NUM_RCAS-1:0]               rca_busy,
    input  logic                              flush,
    output logic [NUM_RCAS-1:0]               use_block,
    input  logic [$clog2(NUM_RCAS)-1:0]       use_rca_sel,
    output logic [5*NUM_READ_PORTS-1:0]       cfg_src_addrs,
    output logic [5*NUM_WRITE_PORTS-1:0]      cfg_dest_addrs,
    output logic                              cfg_valid,
    output logic                              wb_valid,
    output logic [ID_W-1:0]                   wb_id,
    input  logic                              wb_ack
);
    localparam int RCA_W  = $clog2(NUM_RCAS);
    localparam int PORT_W = $clog2(NUM_READ_PORTS);

    // state | meaning
    // IDLE  | ready for a config instruction
    // WAIT  | commit pending, blocking use issue until the target RCA drains
    // WB    | completion presented to writeback
    typedef enum logic [1:0] {IDLE, WAIT, WB} state_t;

    state_t state, state_next;

    logic [4:0]          shadow_src  [NUM_RCAS][NUM_READ_PORTS];
    logic [4:0]          shadow_dest [NUM_RCAS][NUM_WRITE_PORTS];
    logic [4:0]          active_src  [NUM_RCAS][NUM_READ_PORTS];
    logic [4:0]          active_dest [NUM_RCAS][NUM_WRITE_PORTS];
    logic [NUM_RCAS-1:0] active_valid;
    logic [RCA_W-1:0]    sel_q;
    logic [ID_W-1:0]     id_q;

    logic                accept;
    logic                busy_sel;
    logic                do_copy;
    logic [NUM_RCAS-1:0] sel_onehot;

    always_comb begin
        sel_onehot = '0;
        busy_sel   = 1'b0;
        for (int r = 0; r < NUM_RCAS; r++) begin
            if (sel_q == RCA_W'(r)) begin
                sel_onehot[r] = 1'b1;
                busy_sel      = rca_busy[r];
            end
        end
    end

    assign accept  = (state == IDLE) && req_valid && !flush;
    assign do_copy = (state == WAIT) && !flush && !busy_sel;

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        use_block  = '0;
        wb_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) state_next = req_commit ? WAIT : WB;
            end
            WAIT: begin
                use_block = sel_onehot;
                if (flush)         state_next = IDLE;
                else if (!busy_sel) state_next = WB;
            end
            WB: begin
                wb_valid = 1'b1;
                if (flush || wb_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign wb_id = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= '0;
            id_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                sel_q <= req_rca_sel;
                id_q  <= req_id;
            end
        end
    end

    // Port indices beyond the bank width never match, so out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_valid <= '0;
            for (int r = 0; r < NUM_RCAS; r++) begin
                for (int p = 0; p < NUM_READ_PORTS; p++) begin
                    shadow_src[r][p] <= '0;
                    active_src[r][p] <= '0;
                end
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    shadow_dest[r][p] <= '0;
                    active_dest[r][p] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < NUM_RCAS; r++) begin
                if (accept && req_rca_sel == RCA_W'(r)) begin
                    for (int p = 0; p < NUM_READ_PORTS; p++)
                        if (!req_src_dest && req_port_sel == PORT_W'(p))
                            shadow_src[r][p] <= req_reg_addr;
                    for (int p = 0; p < NUM_WRITE_PORTS; p++)
                        if (req_src_dest && req_port_sel == PORT_W'(p))
                            shadow_dest[r][p] <= req_reg_addr;
                end
                if (do_copy && sel_onehot[r]) begin
                    active_valid[r] <= 1'b1;
                    for (int p = 0; p < NUM_READ_PORTS; p++)
                        active_src[r][p] <= shadow_src[r][p];
                    for (int p = 0; p < NUM_WRITE_PORTS; p++)
                        active_dest[r][p] <= shadow_dest[r][p];
                end
            end
        end
    end

    always_comb begin
        cfg_src_addrs  = '0;
        cfg_dest_addrs = '0;
        cfg_valid      = 1'b0;
        for (int r = 0; r < NUM_RCAS; r++) begin
            if (use_rca_sel == RCA_W'(r)) begin
                cfg_valid = active_valid[r];
                for (int p = 0; p < NUM_READ_PORTS; p++)
                    cfg_src_addrs[5*p +: 5] = active_src[r][p];
                for (int p = 0; p < NUM_WRITE_PORTS; p++)
                    cfg_dest_addrs[5*p +: 5] = active_dest[r][p];
            end
        end
    end

endmodule

// File: tb/tb_rca_config_ctrl.sv
// Bench for rca_config_ctrl: directed scenarios then random config traffic against
// an array-based model of the shadow/active banks.
module tb_rca_config_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_rca_sel;
    logic [2:0]  req_port_sel;
    logic        req_src_dest;
    logic [4:0]  req_reg_addr;
    logic        req_commit;
    logic [2:0]  req_id;
    logic [2:0]  rca_busy;
    logic        flush;
    logic [2:0]  use_block;
    logic [1:0]  use_rca_sel;
    logic [24:0] cfg_src_addrs;
    logic [9:0]  cfg_dest_addrs;
    logic        cfg_valid;
    logic        wb_valid;
    logic [2:0]  wb_id;
    logic        wb_ack;

    int checks = 0;
    int errors = 0;

    logic [4:0] m_sh_src [3][5];
    logic [4:0] m_sh_dst [3][2];
    logic [4:0] m_ac_src [3][5];
    logic [4:0] m_ac_dst [3][2];
    logic       m_valid  [3];

    rca_config_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rca_sel(req_rca_sel), .req_port_sel(req_port_sel),
        .req_src_dest(req_src_dest), .req_reg_addr(req_reg_addr),
        .req_commit(req_commit), .req_id(req_id),
        .rca_busy(rca_busy), .flush(flush), .use_block(use_block),
        .use_rca_sel(use_rca_sel), .cfg_src_addrs(cfg_src_addrs),
        .cfg_dest_addrs(cfg_dest_addrs), .cfg_valid(cfg_valid),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] exp_src(input int r);
        logic [24:0] v = '0;
        for (int p = 0; p < 5; p++) v[5*p +: 5] = m_ac_src[r][p];
        return v;
    endfunction

    function automatic logic [9:0] exp_dst(input int r);
        logic [9:0] v = '0;
        for (int p = 0; p < 2; p++) v[5*p +: 5] = m_ac_dst[r][p];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 3; r++) begin
            m_valid[r] = 1'b0;
            for (int p = 0; p < 5; p++) begin m_sh_src[r][p] = '0; m_ac_src[r][p] = '0; end
            for (int p = 0; p < 2; p++) begin m_sh_dst[r][p] = '0; m_ac_dst[r][p] = '0; end
        end
    endtask

    task automatic check_cfg_all(input string tag);
        for (int r = 0; r < 3; r++) begin
            use_rca_sel = 2'(r);
            #1;
            chk($sformatf("%s_src%0d", tag, r), 32'(cfg_src_addrs), 32'(exp_src(r)));
            chk($sformatf("%s_dst%0d", tag, r), 32'(cfg_dest_addrs), 32'(exp_dst(r)));
            chk($sformatf("%s_vld%0d", tag, r), 32'(cfg_valid), 32'(m_valid[r]));
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_req(input int sel, input int port, input int sd, input int addr,
                           input int commit, input int id, input int busy_n,
                           input int flush_wait, input int flush_wb, input int ack_delay);
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_rca_sel = 2'(sel); req_port_sel = 3'(port);
        req_src_dest = 1'(sd); req_reg_addr = 5'(addr); req_commit = 1'(commit);
        req_id = 3'(id); rca_busy = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (sd == 0 && port < 5) m_sh_src[sel][port] = 5'(addr);
        if (sd == 1 && port < 2) m_sh_dst[sel][port] = 5'(addr);
        if (commit != 0) begin
            for (int c = 0; c <= busy_n; c++) begin
                rca_busy = 3'($urandom) & ~(3'b001 << sel);
                if (c < busy_n) rca_busy[sel] = 1'b1;
                chk("use_block_wait", 32'(use_block), 32'(3'b001 << sel));
                chk("wb_valid_wait", 32'(wb_valid), 0);
                use_rca_sel = 2'(c % 3);
                #1;
                chk("cfg_src_wait", 32'(cfg_src_addrs), 32'(exp_src(c % 3)));
                chk("cfg_vld_wait", 32'(cfg_valid), 32'(m_valid[c % 3]));
                if (c == flush_wait) begin
                    flush = 1'b1;
                    @(posedge clk); #1;
                    flush = 1'b0; rca_busy = '0;
                    chk("use_block_flush", 32'(use_block), 0);
                    chk("wb_valid_flush", 32'(wb_valid), 0);
                    chk("req_ready_flush", 32'(req_ready), 1);
                    check_cfg_all("flush_wait");
                    return;
                end
                @(posedge clk); #1;
            end
            rca_busy = '0;
            m_valid[sel] = 1'b1;
            for (int p = 0; p < 5; p++) m_ac_src[sel][p] = m_sh_src[sel][p];
            for (int p = 0; p < 2; p++) m_ac_dst[sel][p] = m_sh_dst[sel][p];
            use_rca_sel = 2'(sel);
            #1;
            chk("cfg_src_first_wb", 32'(cfg_src_addrs), 32'(exp_src(sel)));
            chk("cfg_dst_first_wb", 32'(cfg_dest_addrs), 32'(exp_dst(sel)));
            chk("cfg_vld_first_wb", 32'(cfg_valid), 1);
        end
        for (int d = 0; d <= ack_delay; d++) begin
            chk("wb_valid", 32'(wb_valid), 1);
            chk("wb_id", 32'(wb_id), 32'(id));
            chk("use_block_wb", 32'(use_block), 0);
            chk("req_ready_wb", 32'(req_ready), 0);
            if (d == ack_delay) begin
                wb_ack = 1'b1;
                flush  = 1'(flush_wb);
            end
            @(posedge clk); #1;
        end
        wb_ack = 1'b0; flush = 1'b0;
        chk("wb_valid_after", 32'(wb_valid), 0);
        chk("req_ready_after", 32'(req_ready), 1);
        check_cfg_all("after");
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_rca_sel = '0; req_port_sel = '0;
        req_src_dest = 1'b0; req_reg_addr = '0; req_commit = 1'b0; req_id = '0;
        rca_busy = '0; flush = 1'b0; use_rca_sel = '0; wb_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_id", 32'(wb_id), 0);
        chk("rst_use_block", 32'(use_block), 0);
        check_cfg_all("rst");

        run_req(1, 2, 0, 7, 0, 5, 0, -1, 0, 0);
        run_req(1, 1, 1, 9, 1, 3, 0, -1, 0, 0);
        use_rca_sel = 2'd1; #1;
        chk("rca1_src2", 32'(cfg_src_addrs[14:10]), 7);
        chk("rca1_dst1", 32'(cfg_dest_addrs[9:5]), 9);
        run_req(2, 0, 0, 21, 1, 6, 4, -1, 0, 1);
        run_req(0, 3, 0, 17, 1, 2, 2, 1, 0, 0);
        run_req(0, 6, 0, 31, 1, 4, 0, -1, 0, 0);
        use_rca_sel = 2'd0; #1;
        chk("rca0_src3_exposed", 32'(cfg_src_addrs[19:15]), 17);
        run_req(1, 4, 1, 30, 1, 1, 0, -1, 0, 0);
        run_req(2, 1, 1, 11, 0, 7, 0, -1, 1, 0);

        wb_ack = 1'b1;
        @(posedge clk); #1;
        wb_ack = 1'b0;
        chk("stray_ack_wb_valid", 32'(wb_valid), 0);
        chk("stray_ack_ready", 32'(req_ready), 1);

        req_valid = 1'b1; req_rca_sel = 2'd2; req_port_sel = 3'd4; req_src_dest = 1'b0;
        req_reg_addr = 5'd13; req_commit = 1'b1; req_id = 3'd5; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_ready", 32'(req_ready), 1);
        chk("idle_flush_block", 32'(use_block), 0);
        chk("idle_flush_wb", 32'(wb_valid), 0);
        run_req(2, 7, 0, 0, 1, 0, 0, -1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int busy_n, fw;
            busy_n = int'($urandom_range(0, 3));
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, busy_n)) : -1;
            run_req(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), busy_n, fw,
                    ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 2)));
        end

        req_valid = 1'b1; req_rca_sel = 2'd1; req_port_sel = 3'd0; req_src_dest = 1'b0;
        req_reg_addr = 5'd19; req_commit = 1'b1; req_id = 3'd6; rca_busy = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_block", 32'(use_block), 32'(3'b010));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_block", 32'(use_block), 0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 0);
        chk("mid_rst_wb_id", 32'(wb_id), 0);
        chk("mid_rst_ready", 32'(req_ready), 1);
        check_cfg_all("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1; rca_busy = '0;
        run_req(0, 1, 0, 3, 1, 2, 1, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rca_config_ctrl.md
# rca_config_ctrl

Sequences reconfiguration of the reconfigurable compute accelerators (RCAs) in the Taiga core. It accepts RCA config instructions from issue one at a time and writes each port's register address into a per-RCA shadow bank. On a commit request it waits until the target RCA has no in-flight use instructions, then atomically copies shadow to active. It returns a completion to writeback and serves the active source/destination register addresses of the RCA selected by the use path.

## Interface
- NUM_RCAS, 3, number of RCAs
- NUM_READ_PORTS, 5, source ports per RCA (rs1..rs5)
- NUM_WRITE_PORTS, 2, destination ports per RCA
- ID_W, 3, instruction id width (log2 MAX_IDS)
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  config instruction valid
- req_ready  out  1  block can accept a request
- req_rca_sel  in  clog2(NUM_RCAS)  target RCA
- req_port_sel  in  clog2(NUM_READ_PORTS)  port index
- req_src_dest  in  1  0 = source port, 1 = destination port
- req_reg_addr  in  5  register address to store
- req_commit  in  1  after the write, copy the shadow bank to the active bank
- req_id  in  ID_W  instruction id
- rca_busy  in  NUM_RCAS  per-RCA: use instructions in flight
- flush  in  1  pipeline flush from gc
- use_block  out  NUM_RCAS  per-RCA: issue must not issue RCA use
- use_rca_sel  in  clog2(NUM_RCAS)  RCA read by the use path
- cfg_src_addrs  out  5*NUM_READ_PORTS  active source addresses of use_rca_sel; port p at [5p+4:5p]
- cfg_dest_addrs  out  5*NUM_WRITE_PORTS  active destination addresses of use_rca_sel
- cfg_valid  out  1  use_rca_sel has been committed at least once
- wb_valid  out  1  completion pending
- wb_id  out  ID_W  id of the completing instruction
- wb_ack  in  1  writeback accepts the completion

## Operation
- States: IDLE, WAIT, WB.
- IDLE
  - req_ready = 1.
  - A request is accepted when req_valid is high in IDLE. On accept, latch req_rca_sel, req_commit and req_id.
  - Write req_reg_addr into the shadow bank for the target RCA. Source port if req_src_dest = 0; destination port if req_src_dest = 1.
  - Out-of-range writes change nothing, and the instruction still completes:
    - source with port ≥ NUM_READ_PORTS
    - destination with port ≥ NUM_WRITE_PORTS
  - Next state is WAIT if req_commit = 1, else WB.
- WAIT
  - use_block[latched sel] = 1.
  - When rca_busy[sel] = 0: copy the entire shadow bank of sel to its active bank, set valid[sel], go to WB.
  - While rca_busy[sel] = 1, stay in WAIT. There is no timeout.
- WB
  - wb_valid = 1, wb_id = latched id.
  - On wb_ack, go to IDLE.
- flush
  - In WAIT or WB: go to IDLE; no copy, no wb_valid afterwards.
  - Shadow writes already made are retained.
  - In IDLE, flush blocks acceptance that cycle.
- Active-bank reads are combinational, indexed by use_rca_sel. Shadow contents are never visible on the cfg outputs.
- Shadow writes and active copies for one RCA never disturb the other RCAs.

## Timing
- Reset values:
  - state IDLE, so req_ready = 1 and wb_valid = 0.
  - use_block = 0, wb_id = 0.
  - All shadow and active registers = 0, all valid bits = 0. So cfg_src_addrs = 0, cfg_dest_addrs = 0, cfg_valid = 0.
- Non-commit request accepted in cycle 0: shadow updated at the end of cycle 0; wb_valid from cycle 1.
- Commit request accepted in cycle 0 with rca_busy clear:
  - WAIT in cycle 1; the copy happens at the end of cycle 1 and includes the cycle-0 write.
  - New cfg outputs and wb_valid from cycle 2.
- Each rca_busy-high cycle in WAIT adds one cycle of latency.
- use_block is asserted exactly during the WAIT cycles.
- wb_ack in the first WB cycle means IDLE next cycle. Throughput is at most one request per 2 cycles (non-commit) or 3 cycles (commit).
- wb_ack outside WB is ignored.
- flush and wb_ack in the same WB cycle: flush wins; the result is IDLE either way.
- rst_n asserted mid-operation: immediate return to reset values, in-flight request discarded.

## Test plan
- Reset, then use_rca_sel = 0 → cfg_src_addrs = 0, cfg_valid = 0, req_ready = 1.
- Write src port 2 = 5'd7 of RCA 1 with no commit → wb_valid in cycle 1 with wb_id = req_id; cfg outputs for RCA 1 unchanged; after wb_ack, req_ready = 1.
- Write dest port 1 = 5'd9 of RCA 1 with commit and rca_busy = 0 → from cycle 2, use_rca_sel = 1 shows src[14:10] = 7, dest[9:5] = 9, cfg_valid = 1; wb_valid in cycle 2.
- Commit to RCA 2 with rca_busy[2] = 1 for 4 cycles → use_block = 3'b100 for 5 cycles, copy only after busy drops; RCA 0 and RCA 1 outputs unchanged throughout.
- Commit to RCA 0, flush during WAIT → no wb_valid, active bank of RCA 0 unchanged, use_block = 0 next cycle, shadow retains the write. A later commit-only request exposes it.
- Dest write with port 4 (≥ NUM_WRITE_PORTS) plus commit → no address changes, completion still issued. Assert rst_n low during WAIT → all outputs return to reset values immediately.
